// File: rtl/ppu_pkg.sv
// Shared types and width helpers for the PPU add/sub datapath.
// Stage payload structs are sized for the default 16-bit posit configuration.
package ppu_pkg;

  function automatic int te_width(input int n, input int es);
    return es + $clog2(n) + 2;
  endfunction

  function automatic int sum_width(input int mant_w);
    return 2 * mant_w + 1;
  endfunction

  localparam int PPU_N      = 16;
  localparam int PPU_ES     = 1;
  localparam int PPU_MANT_W = PPU_N;
  localparam int PPU_TE_W   = te_width(PPU_N, PPU_ES);
  localparam int PPU_DW     = 2 * PPU_MANT_W;
  localparam int PPU_SUM_W  = sum_width(PPU_MANT_W);
  localparam int PPU_SH_W   = $clog2(PPU_DW + 1);

  // Ordered operands waiting for alignment.
  typedef struct packed {
    logic [PPU_TE_W-1:0]   te;
    logic [PPU_MANT_W-1:0] mant_big;
    logic [PPU_MANT_W-1:0] mant_small;
    logic [PPU_SH_W-1:0]   shift;
    logic                  sign;
    logic                  opp;
  } order_t;

  typedef struct packed {
    logic [PPU_TE_W-1:0]  te;
    logic [PPU_SUM_W-1:0] sum;
    logic                 sign;
    logic                 sticky;
  } align_t;

  typedef struct packed {
    logic [PPU_TE_W-1:0] te;
    logic [PPU_DW-1:0]   mant;
    logic                sign;
    logic                sticky;
    logic                zero;
  } norm_t;

endpackage

// File: rtl/lzc.sv
// Parametrised leading-zero counter; cnt = W when the input is all zeros.
module lzc #(
  parameter int W = 32,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     din,
  output logic [CNT_W-1:0] cnt,
  output logic             all_zero
);

  always_comb begin
    cnt = CNT_W'(W);
    // Later (higher) set bits override, so the MSB-most one wins.
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CNT_W'(W - 1 - i);
    end
  end

  assign all_zero = ~|din;

endmodule

// File: rtl/core_add_sub_pipe.sv
// Three-stage posit add/sub core: order, align/add, normalise.
// All stages share one advance enable so a stalled output freezes the pipe.
module core_add_sub_pipe
  import ppu_pkg::*;
#(
  parameter int N      = PPU_N,
  parameter int ES     = PPU_ES,
  parameter int MANT_W = N,
  parameter int TE_W   = te_width(N, ES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [TE_W-1:0]     te1,
  input  logic [TE_W-1:0]     te2,
  input  logic [MANT_W-1:0]   mant1,
  input  logic [MANT_W-1:0]   mant2,
  input  logic                sign1,
  input  logic                sign2,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TE_W-1:0]     te_out,
  output logic [2*MANT_W-1:0] mant_out,
  output logic                sign_out,
  output logic                sticky_out,
  output logic                zero_out
);

  localparam int DW    = 2 * MANT_W;
  localparam int SUM_W = sum_width(MANT_W);
  localparam int SH_W  = $clog2(DW + 1);
  localparam int LZ_W  = $clog2(DW + 1);

  // The stage structs come from the package, so the widths must line up.
  if (MANT_W != PPU_MANT_W || TE_W != PPU_TE_W) begin : g_cfg_check
    $error("core_add_sub_pipe: parameters do not match ppu_pkg payload widths");
  end

  logic   adv;
  logic   s1_v, s2_v, s3_v;
  order_t s1_c, s1_q;
  align_t s2_c, s2_q;
  norm_t  s3_c, s3_q;

  assign adv      = !s3_v || out_ready;
  assign in_ready = adv;

  // Stage 1: order by magnitude and compute the saturated alignment shift.
  logic            s2e, op2_big;
  logic [TE_W:0]   te_diff;

  always_comb begin
    s2e     = sign2 ^ sub;
    op2_big = ($signed(te2) > $signed(te1)) || ((te2 == te1) && (mant2 > mant1));
    s1_c     = '0;
    s1_c.opp = sign1 ^ s2e;
    if (op2_big) begin
      s1_c.te         = te2;
      s1_c.mant_big   = mant2;
      s1_c.mant_small = mant1;
      s1_c.sign       = s2e;
      te_diff         = {te2[TE_W-1], te2} - {te1[TE_W-1], te1};
    end else begin
      s1_c.te         = te1;
      s1_c.mant_big   = mant1;
      s1_c.mant_small = mant2;
      s1_c.sign       = sign1;
      te_diff         = {te1[TE_W-1], te1} - {te2[TE_W-1], te2};
    end
    if (te_diff > (TE_W+1)'(DW)) s1_c.shift = SH_W'(DW);
    else                         s1_c.shift = te_diff[SH_W-1:0];
  end

  // Stage 2: align the small operand, collect sticky, add or subtract.
  logic [DW-1:0]    big_ext;
  logic [2*DW-1:0]  small_wide;
  logic [SUM_W-1:0] small_op;

  always_comb begin
    big_ext    = {s1_q.mant_big, {MANT_W{1'b0}}};
    small_wide = {s1_q.mant_small, {(2*DW-MANT_W){1'b0}}} >> s1_q.shift;
    small_op   = {1'b0, small_wide[2*DW-1:DW]};
    s2_c        = '0;
    s2_c.te     = s1_q.te;
    s2_c.sign   = s1_q.sign;
    s2_c.sticky = |small_wide[DW-1:0];
    if (s1_q.opp) s2_c.sum = {1'b0, big_ext} + ~small_op + SUM_W'(1);
    else          s2_c.sum = {1'b0, big_ext} + small_op;
  end

  // Stage 3: normalise on carry, cancellation or leading zeros.
  logic [LZ_W-1:0] lz;
  logic            sum_lo_zero;

  lzc #(.W(DW), .CNT_W(LZ_W)) u_lzc (
    .din      (s2_q.sum[DW-1:0]),
    .cnt      (lz),
    .all_zero (sum_lo_zero)
  );

  always_comb begin
    s3_c        = '0;
    s3_c.sign   = s2_q.sign;
    s3_c.sticky = s2_q.sticky;
    if (s2_q.sum[DW]) begin
      s3_c.mant   = s2_q.sum[DW:1];
      s3_c.te     = s2_q.te + TE_W'(1);
      s3_c.sticky = s2_q.sticky | s2_q.sum[0];
    end else if (sum_lo_zero) begin
      s3_c      = '0;
      s3_c.zero = 1'b1;
    end else begin
      s3_c.mant = s2_q.sum[DW-1:0] << lz;
      s3_c.te   = s2_q.te - TE_W'(lz);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (adv) begin
      s1_v <= in_valid;
      s2_v <= s1_v;
      s3_v <= s2_v;
      if (in_valid) s1_q <= s1_c;
      if (s1_v)     s2_q <= s2_c;
      if (s2_v)     s3_q <= s3_c;
    end
  end

  assign out_valid  = s3_v;
  assign te_out     = s3_q.te;
  assign mant_out   = s3_q.mant;
  assign sign_out   = s3_q.sign;
  assign sticky_out = s3_q.sticky;
  assign zero_out   = s3_q.zero;

endmodule

// File: tb/tb_core_add_sub_pipe.sv
// Directed self-checking bench for core_add_sub_pipe (default N=16, ES=1).
module tb_core_add_sub_pipe;

  localparam int TE_W   = 7;
  localparam int MANT_W = 16;
  localparam int DW     = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic [TE_W-1:0]   te1, te2;
  logic [MANT_W-1:0] mant1, mant2;
  logic              sign1, sign2, sub;
  logic              out_valid, out_ready;
  logic [TE_W-1:0]   te_out;
  logic [DW-1:0]     mant_out;
  logic              sign_out, sticky_out, zero_out;

  int tests_run    = 0;
  int tests_failed = 0;

  core_add_sub_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .te1        (te1),
    .te2        (te2),
    .mant1      (mant1),
    .mant2      (mant2),
    .sign1      (sign1),
    .sign2      (sign2),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .te_out     (te_out),
    .mant_out   (mant_out),
    .sign_out   (sign_out),
    .sticky_out (sticky_out),
    .zero_out   (zero_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TE_W-1:0]   te1, te2;
    logic [MANT_W-1:0] m1, m2;
    logic              sg1, sg2, op;
    logic [TE_W-1:0]   te_x;
    logic [DW-1:0]     m_x;
    logic              sg_x, st_x, z_x;
  } vec_t;

  vec_t add_v[5];
  vec_t sub_v[7];
  vec_t stream_v[5];

  task automatic init_tables();
    // te1, te2, mant1, mant2, sign1, sign2, sub | te, mant, sign, sticky, zero
    add_v[0] = '{7'd0, 7'd0,      16'h8000, 16'h8000, 0, 0, 0, 7'd1, 32'h8000_0000, 0, 0, 0};
    add_v[1] = '{7'd0, 7'(-40),   16'h8000, 16'h8000, 0, 0, 0, 7'd0, 32'h8000_0000, 0, 1, 0};
    add_v[2] = '{7'd0, 7'(-31),   16'h8000, 16'h8000, 0, 0, 0, 7'd0, 32'h8000_0001, 0, 0, 0};
    add_v[3] = '{7'd0, 7'(-32),   16'h8000, 16'h8000, 0, 0, 0, 7'd0, 32'h8000_0000, 0, 1, 0};
    add_v[4] = '{7'd0, 7'(-17),   16'h8000, 16'h8001, 0, 0, 0, 7'd0, 32'h8000_4000, 0, 1, 0};
    sub_v[0] = '{7'd0, 7'd0,      16'h8000, 16'h8000, 0, 0, 1, 7'd0, 32'h0000_0000, 0, 0, 1};
    sub_v[1] = '{7'd0, 7'd2,      16'h8000, 16'hC000, 0, 0, 1, 7'd2, 32'hA000_0000, 1, 0, 0};
    sub_v[2] = '{7'd0, 7'd0,      16'hC000, 16'h8000, 0, 0, 1, 7'(-1), 32'h8000_0000, 0, 0, 0};
    sub_v[3] = '{7'd1, 7'd0,      16'h8000, 16'h8000, 1, 0, 0, 7'd0, 32'h8000_0000, 1, 0, 0};
    sub_v[4] = '{7'd0, 7'd0,      16'h8000, 16'h8000, 1, 1, 1, 7'd0, 32'h0000_0000, 0, 0, 1};
    sub_v[5] = '{7'd0, 7'(-40),   16'h8000, 16'h8000, 0, 0, 1, 7'd0, 32'h8000_0000, 0, 1, 0};
    sub_v[6] = '{7'd0, 7'd0,      16'h8000, 16'hC000, 0, 0, 1, 7'(-1), 32'h8000_0000, 1, 0, 0};
    stream_v[0] = add_v[0];
    stream_v[1] = sub_v[1];
    stream_v[2] = add_v[4];
    stream_v[3] = sub_v[2];
    stream_v[4] = sub_v[3];
  endtask

  task automatic apply(input vec_t v);
    te1 = v.te1; te2 = v.te2; mant1 = v.m1; mant2 = v.m2;
    sign1 = v.sg1; sign2 = v.sg2; sub = v.op; in_valid = 1'b1;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_handshake: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
    tests_run++;
    if ({te_out, mant_out, sign_out, sticky_out, zero_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got te=%h mant=%h s=%b st=%b z=%b, expected all zero",
               te_out, mant_out, sign_out, sticky_out, zero_out);
    end
  endtask

  task automatic test_add();
    int cyc;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      apply(add_v[i]);
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL add[%0d] in_ready: got %b, expected 1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(cyc);
      tests_run++;
      if (cyc !== 3) begin
        tests_failed++;
        $display("FAIL add[%0d] latency: got %0d cycles, expected 3", i, cyc);
      end
      tests_run++;
      if ({te_out, mant_out, sign_out, sticky_out, zero_out} !==
          {add_v[i].te_x, add_v[i].m_x, add_v[i].sg_x, add_v[i].st_x, add_v[i].z_x}) begin
        tests_failed++;
        $display("FAIL add[%0d] result: got te=%h mant=%h s=%b st=%b z=%b, expected te=%h mant=%h s=%b st=%b z=%b",
                 i, te_out, mant_out, sign_out, sticky_out, zero_out,
                 add_v[i].te_x, add_v[i].m_x, add_v[i].sg_x, add_v[i].st_x, add_v[i].z_x);
      end
    end
  endtask

  task automatic test_sub();
    int cyc;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      apply(sub_v[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(cyc);
      tests_run++;
      if (cyc !== 3) begin
        tests_failed++;
        $display("FAIL sub[%0d] latency: got %0d cycles, expected 3", i, cyc);
      end
      tests_run++;
      if ({te_out, mant_out, sign_out, sticky_out, zero_out} !==
          {sub_v[i].te_x, sub_v[i].m_x, sub_v[i].sg_x, sub_v[i].st_x, sub_v[i].z_x}) begin
        tests_failed++;
        $display("FAIL sub[%0d] result: got te=%h mant=%h s=%b st=%b z=%b, expected te=%h mant=%h s=%b st=%b z=%b",
                 i, te_out, mant_out, sign_out, sticky_out, zero_out,
                 sub_v[i].te_x, sub_v[i].m_x, sub_v[i].sg_x, sub_v[i].st_x, sub_v[i].z_x);
      end
    end
  endtask

  task automatic test_back_to_back();
    int              got;
    logic            held;
    logic [TE_W-1:0] h_te;
    logic [DW-1:0]   h_m;
    logic [2:0]      h_f;
    @(posedge clk); #1;
    out_ready = 1'b1;
    got  = 0;
    held = 1'b0;
    h_te = '0; h_m = '0; h_f = '0;
    fork
      begin : driver
        logic rdy, acc;
        for (int i = 0; i < 5; i++) begin
          apply(stream_v[i]);
          acc = 1'b0;
          for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            acc = rdy;
          end
          if (!acc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL b2b accept[%0d]: got no accept in 20 cycles, expected accept", i);
          end
        end
        in_valid = 1'b0;
      end
      begin : monitor
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (held) begin
            tests_run++;
            if (!out_valid || te_out !== h_te || mant_out !== h_m ||
                {sign_out, sticky_out, zero_out} !== h_f) begin
              tests_failed++;
              $display("FAIL b2b hold c%0d: got v=%b te=%h mant=%h, expected v=1 te=%h mant=%h",
                       c, out_valid, te_out, mant_out, h_te, h_m);
            end
          end
          if (out_valid && !out_ready) begin
            tests_run++;
            if (in_ready !== 1'b0) begin
              tests_failed++;
              $display("FAIL b2b stall in_ready c%0d: got %b, expected 0", c, in_ready);
            end
            held = 1'b1;
            h_te = te_out; h_m = mant_out; h_f = {sign_out, sticky_out, zero_out};
          end else begin
            held = 1'b0;
          end
          if (out_valid && out_ready) begin
            tests_run++;
            if (got >= 5) begin
              tests_failed++;
              $display("FAIL b2b extra result: got result #%0d te=%h mant=%h, expected only 5", got, te_out, mant_out);
            end else if ({te_out, mant_out, sign_out, sticky_out, zero_out} !==
                         {stream_v[got].te_x, stream_v[got].m_x, stream_v[got].sg_x,
                          stream_v[got].st_x, stream_v[got].z_x}) begin
              tests_failed++;
              $display("FAIL b2b result[%0d]: got te=%h mant=%h s=%b st=%b z=%b, expected te=%h mant=%h s=%b st=%b z=%b",
                       got, te_out, mant_out, sign_out, sticky_out, zero_out,
                       stream_v[got].te_x, stream_v[got].m_x, stream_v[got].sg_x,
                       stream_v[got].st_x, stream_v[got].z_x);
            end
            got++;
          end
          @(posedge clk); #1;
          out_ready = !(c >= 3 && c < 6);
        end
      end
    join
    tests_run++;
    if (got !== 5) begin
      tests_failed++;
      $display("FAIL b2b count: got %0d results, expected 5", got);
    end
  endtask

  task automatic test_reset_inflight();
    logic stale;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(add_v[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_inflight pre: got out_valid=%b, expected 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL rst_inflight async: got out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_inflight release in_ready: got %b, expected 1", in_ready);
    end
    stale = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    tests_run++;
    if (stale !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_inflight stale: got out_valid after release, expected none");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at 100us, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    te1 = '0; te2 = '0; mant1 = '0; mant2 = '0;
    sign1 = 1'b0; sign2 = 1'b0; sub = 1'b0;
    init_tables();
    #7;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
